// File: rtl/friscv_io_master.sv
// rtl/friscv_io_master.sv - single-outstanding IO bus initiator with address window decode and access watchdog
module friscv_io_master #(
  parameter int unsigned ADDRW     = 16,
  parameter int unsigned XLEN      = 32,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                aclk,
  input  logic                srst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [XLEN/8-1:0]   req_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic                mst_en,
  output logic                mst_wr,
  output logic [ADDRW-1:0]    mst_addr,
  output logic [XLEN-1:0]     mst_wdata,
  output logic [XLEN/8-1:0]   mst_strb,
  input  logic [XLEN-1:0]     mst_rdata,
  input  logic                mst_ready
);

  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] BASE_L  = BASE_ADDR[XLEN-1:0];

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [WDW-1:0]      wdog_q, wdog_d;
  logic                mst_wr_q, mst_wr_d;
  logic [ADDRW-1:0]    mst_addr_q, mst_addr_d;
  logic [XLEN-1:0]     mst_wdata_q, mst_wdata_d;
  logic [XLEN/8-1:0]   mst_strb_q, mst_strb_d;
  logic [XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [XLEN-1:0]     offset;
  logic                in_window;

  // Wrapping subtraction plus the lower-bound compare keeps addresses below BASE out of the window.
  assign offset    = req_addr - BASE_L;
  assign in_window = (req_addr >= BASE_L) && ((offset >> ADDRW) == '0);

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    mst_wr_d    = mst_wr_q;
    mst_addr_d  = mst_addr_q;
    mst_wdata_d = mst_wdata_q;
    mst_strb_d  = mst_strb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rsp_rdata_d = '0;
          if (in_window) begin
            mst_wr_d    = req_wr;
            mst_addr_d  = offset[ADDRW-1:0];
            mst_wdata_d = req_wdata;
            mst_strb_d  = req_strb;
            rsp_err_d   = 1'b0;
            wdog_d      = '0;
            state_d     = ACCESS;
          end else begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
      ACCESS: begin
        // A ready slave on the final watchdog cycle still completes normally.
        if (mst_ready) begin
          rsp_rdata_d = mst_wr_q ? '0 : mst_rdata;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if ((TIMEOUT != 0) && (wdog_q == WD_LAST)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q     <= IDLE;
      wdog_q      <= '0;
      mst_wr_q    <= 1'b0;
      mst_addr_q  <= '0;
      mst_wdata_q <= '0;
      mst_strb_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      mst_wr_q    <= mst_wr_d;
      mst_addr_q  <= mst_addr_d;
      mst_wdata_q <= mst_wdata_d;
      mst_strb_q  <= mst_strb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mst_en    = (state_q == ACCESS);
  assign rsp_valid = (state_q == RESP);
  assign mst_wr    = mst_wr_q;
  assign mst_addr  = mst_addr_q;
  assign mst_wdata = mst_wdata_q;
  assign mst_strb  = mst_strb_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
